// File: rtl/chunked_addsub_pkg.sv
// chunked_addsub shared definitions: FSM encoding, default sizes, helpers.
// Optional signed-overflow logic is enabled by CHUNKED_ADDSUB_OVF_EN.
package chunked_addsub_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CHUNK = 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   function automatic int nchunk(input int w, input int c);
      return (c > 0) ? (w / c) : 1;
   endfunction

endpackage

// File: rtl/chunked_addsub_if.sv
// Operand/result handshake bundle for chunked_addsub.
// Optional signed-overflow logic is enabled by CHUNKED_ADDSUB_OVF_EN.
interface chunked_addsub_if
   import chunked_addsub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;

   modport master (
      output in_valid, a, b, sub, cin, out_ready,
      input  in_ready, out_valid, result, carry_out, overflow
   );

   modport slave (
      input  in_valid, a, b, sub, cin, out_ready,
      output in_ready, out_valid, result, carry_out, overflow
   );

endinterface

// File: rtl/chunked_addsub_chunk_adder.sv
// Combinational CHUNK-bit slice adder shared across all slices.
// Carry-into-MSB output exists only when CHUNKED_ADDSUB_OVF_EN is defined.
module chunk_adder
   import chunked_addsub_pkg::*;
#(
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic [CHUNK-1:0] i_a,
   input  logic [CHUNK-1:0] i_b,
   input  logic             i_cin,
   output logic [CHUNK-1:0] o_sum,
   output logic             o_cout
`ifdef CHUNKED_ADDSUB_OVF_EN
   ,
   output logic             o_cmsb
`endif
);

   logic [CHUNK:0] w_full;

   assign w_full = {1'b0, i_a} + {1'b0, i_b}
                 + {{CHUNK{1'b0}}, i_cin};
   assign o_sum  = w_full[CHUNK-1:0];
   assign o_cout = w_full[CHUNK];

`ifdef CHUNKED_ADDSUB_OVF_EN
   // carry into the top bit recovered from sum and operand bits
   assign o_cmsb = w_full[CHUNK-1] ^ i_a[CHUNK-1] ^ i_b[CHUNK-1];
`endif

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract, one CHUNK-bit slice per clock, LSB first.
// Signed overflow flag is computed only when CHUNKED_ADDSUB_OVF_EN is defined.
module chunked_addsub
   import chunked_addsub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input logic             i_clk,
   input logic             i_reset,
   chunked_addsub_if.slave bus
);

   localparam int NCH = nchunk(WIDTH, CHUNK);
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCH - 1);

   generate
      if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad
         $error("chunked_addsub: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic [IW-1:0]    r_idx;
   logic             r_carry;
   logic             r_cout;

   logic [CHUNK-1:0] w_a_sl;
   logic [CHUNK-1:0] w_b_sl;
   logic [CHUNK-1:0] w_sum;
   logic             w_cout;
   logic             w_accept;
   logic             w_fin;

   assign w_a_sl   = r_a[int'(r_idx) * CHUNK +: CHUNK];
   assign w_b_sl   = r_b[int'(r_idx) * CHUNK +: CHUNK];
   assign w_accept = bus.in_valid && (r_state == S_IDLE);
   assign w_fin    = (r_state == S_RUN) && (r_idx == LAST);

`ifdef CHUNKED_ADDSUB_OVF_EN
   logic w_cmsb;
   logic r_ovf;

   chunk_adder #(.CHUNK(CHUNK)) u_add (
      .i_a    (w_a_sl),
      .i_b    (w_b_sl),
      .i_cin  (r_carry),
      .o_sum  (w_sum),
      .o_cout (w_cout),
      .o_cmsb (w_cmsb)
   );

   // overflow flag: cleared on accept, latched on the top slice
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ovf <= 1'b0;
      end else if (w_accept) begin
         r_ovf <= 1'b0;
      end else if (w_fin) begin
         r_ovf <= w_cmsb ^ w_cout;
      end
   end

   assign bus.overflow = r_ovf;
`else
   chunk_adder #(.CHUNK(CHUNK)) u_add (
      .i_a    (w_a_sl),
      .i_b    (w_b_sl),
      .i_cin  (r_carry),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   assign bus.overflow = 1'b0;
`endif

   // control FSM and slice datapath
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_cout   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_a      <= bus.a;
                  r_b      <= bus.b ^ {WIDTH{bus.sub}};
                  r_carry  <= bus.cin;
                  r_result <= '0;
                  r_cout   <= 1'b0;
                  r_idx    <= '0;
                  r_state  <= S_RUN;
               end
            end
            S_RUN: begin
               r_result[int'(r_idx) * CHUNK +: CHUNK] <= w_sum;
               r_carry <= w_cout;
               if (r_idx == LAST) begin
                  r_cout  <= w_cout;
                  r_state <= S_DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.result    = r_result;
   assign bus.carry_out = r_cout;

endmodule

// File: tb/tb_chunked_addsub.sv
// Directed testbench for chunked_addsub at WIDTH=16, CHUNK=4.
// Overflow expectations follow CHUNKED_ADDSUB_OVF_EN.
module tb_chunked_addsub;

`ifdef CHUNKED_ADDSUB_OVF_EN
   localparam bit OVF = 1'b1;
`else
   localparam bit OVF = 1'b0;
`endif

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   chunked_addsub_if #(.WIDTH(16)) bus ();

   chunked_addsub #(.WIDTH(16), .CHUNK(4)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic run_op(
      input  logic [15:0] ta,
      input  logic [15:0] tb_,
      input  logic        ts,
      input  logic        tc,
      output logic [15:0] res,
      output logic        co,
      output logic        ov,
      output int          lat
   );
      int w;
      bus.a        = ta;
      bus.b        = tb_;
      bus.sub      = ts;
      bus.cin      = tc;
      bus.in_valid = 1'b1;
      w = 0;
      while (!bus.in_ready && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.a        = 16'hDEAD;
      bus.b        = 16'hBEEF;
      bus.sub      = ~ts;
      bus.cin      = ~tc;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      res = bus.result;
      co  = bus.carry_out;
      ov  = bus.overflow;
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks += 5;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_in_ready got %b want 1", bus.in_ready);
      end
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_out_valid got %b want 0", bus.out_valid);
      end
      if (bus.result !== 16'h0000) begin
         n_fail++;
         $display("FAIL rst_result got %h want 0000", bus.result);
      end
      if (bus.carry_out !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_carry got %b want 0", bus.carry_out);
      end
      if (bus.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ovf got %b want 0", bus.overflow);
      end
   endtask

   task automatic test_vec(
      input string       nm,
      input logic [15:0] ta,
      input logic [15:0] tb_,
      input logic        ts,
      input logic        tc,
      input logic [15:0] er,
      input logic        ec,
      input logic        eo
   );
      logic [15:0] res;
      logic        co;
      logic        ov;
      int          lat;
      run_op(ta, tb_, ts, tc, res, co, ov, lat);
      n_checks += 5;
      if (lat !== 4) begin
         n_fail++;
         $display("FAIL %s_latency got %0d want 4", nm, lat);
      end
      if (res !== er) begin
         n_fail++;
         $display("FAIL %s_result got %h want %h", nm, res, er);
      end
      if (co !== ec) begin
         n_fail++;
         $display("FAIL %s_carry got %b want %b", nm, co, ec);
      end
      if (ov !== eo) begin
         n_fail++;
         $display("FAIL %s_ovf got %b want %b", nm, ov, eo);
      end
      if (bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_in_ready got %b want 0", nm, bus.in_ready);
      end
      consume();
   endtask

   task automatic test_backpressure();
      logic [15:0] res;
      logic        co;
      logic        ov;
      int          lat;
      run_op(16'h1111, 16'h2222, 1'b0, 1'b0, res, co, ov, lat);
      n_checks++;
      if (res !== 16'h3333) begin
         n_fail++;
         $display("FAIL bp_result got %h want 3333", res);
      end
      bus.a        = 16'hAAAA;
      bus.b        = 16'h5555;
      bus.sub      = 1'b1;
      bus.cin      = 1'b1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks += 3;
         if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold_valid got %b want 1", bus.out_valid);
         end
         if (bus.result !== 16'h3333) begin
            n_fail++;
            $display("FAIL bp_hold_result got %h want 3333", bus.result);
         end
         if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold_ready got %b want 0", bus.in_ready);
         end
      end
      bus.in_valid = 1'b0;
      consume();
      n_checks += 3;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_post_ready got %b want 1", bus.in_ready);
      end
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_post_valid got %b want 0", bus.out_valid);
      end
      if (bus.result !== 16'h3333) begin
         n_fail++;
         $display("FAIL bp_retain got %h want 3333", bus.result);
      end
      test_vec("bp_next", 16'h0001, 16'h0002, 1'b0, 1'b0,
               16'h0003, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_run();
      bus.a        = 16'hFFFF;
      bus.b        = 16'h0001;
      bus.sub      = 1'b0;
      bus.cin      = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks += 4;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_rst_valid got %b want 0", bus.out_valid);
      end
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_rst_ready got %b want 1", bus.in_ready);
      end
      if (bus.result !== 16'h0000) begin
         n_fail++;
         $display("FAIL mid_rst_result got %h want 0000", bus.result);
      end
      if (bus.carry_out !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_rst_carry got %b want 0", bus.carry_out);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_quiet got %b want 0", bus.out_valid);
         end
      end
      test_vec("post_rst", 16'h1234, 16'h0FFF, 1'b0, 1'b0,
               16'h2233, 1'b0, 1'b0);
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.sub       = 1'b0;
      bus.cin       = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_vec("add", 16'h1234, 16'h0FFF, 1'b0, 1'b0,
               16'h2233, 1'b0, 1'b0);
      test_vec("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1,
               16'hFFFE, 1'b0, 1'b0);
      test_vec("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0,
               16'h8000, 1'b0, OVF);
      test_vec("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1,
               16'h7FFF, 1'b1, OVF);
      test_vec("ripple", 16'hFFFF, 16'h0000, 1'b0, 1'b1,
               16'h0000, 1'b1, 1'b0);
      test_vec("sub_m1", 16'h0010, 16'h0003, 1'b1, 1'b0,
               16'h000C, 1'b1, 1'b0);
      test_backpressure();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/chunked_addsub.md
# chunked_addsub

Parametrised multi-cycle adder/subtractor processing a WIDTH-bit operand pair in CHUNK-bit slices, one slice per clock, LSB first. Replaces the fixed 4-bit ripple subtractor in arithmetic datapaths where width must scale without a full-width carry chain in one cycle. Operands arrive over a valid/ready input handshake; the result is returned over a valid/ready output handshake with carry and signed-overflow flags.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend/augend.
- b  input  WIDTH  subtrahend/addend.
- sub  input  1  0 = add, 1 = subtract.
- cin  input  1  raw carry into bit 0 in both modes.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  sum/difference.
- carry_out  output  1  carry out of MSB; in subtract mode 1 = no borrow.
- overflow  output  1  two's-complement overflow.

## Operation
- Arithmetic: result = a + (sub ? ~b : b) + cin, modulo 2^WIDTH. True a−b requires sub=1, cin=1; a−b−1 uses cin=0.
- overflow = carry into MSB XOR carry_out.
- NCHUNK = WIDTH/CHUNK.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, register a, b^{WIDTH{sub}}, cin; clear result; chunk index=0; go RUN.
- RUN: each cycle add slice [idx*CHUNK +: CHUNK] with registered carry; write slice into result register, update carry. On idx=NCHUNK−1, latch carry_out and overflow; go DONE. Otherwise idx+1.
- DONE: out_valid=1; result/carry_out/overflow held stable. On out_ready, go IDLE.
- Inputs not sampled outside the acceptance edge; in_valid ignored in RUN/DONE.
- result, carry_out, overflow retain last value after DONE→IDLE until the next acceptance clears them.
- Invalid parameters (WIDTH % CHUNK ≠ 0): elaboration-time error.

## Timing
- Reset: state=IDLE, out_valid=0, result=0, carry_out=0, overflow=0, idx=0, carry reg=0; in_ready=1 from the first cycle after reset deasserts.
- in_ready and out_valid are decoded from state only; no combinational path from any input.
- Acceptance at edge k → out_valid rises at edge k+NCHUNK (4 cycles at defaults).
- Consumption at edge m (out_valid&out_ready) → in_ready=1 from edge m; earliest next acceptance at edge m+1. No same-cycle turnaround.
- Throughput: one operation per NCHUNK+2 cycles with out_ready tied high.
- Reset in any state, including mid-RUN: operation discarded, reset values next cycle; no output produced.
- CHUNK=WIDTH: RUN lasts one cycle.

## Configuration
- CHUNKED_ADDSUB_OVF_EN defined: overflow computed as above.
- Undefined: overflow tied to 0, MSB carry-in tracking logic removed; port still present; all other behaviour identical.

## Structure
- Package chunked_addsub_pkg: state encoding (IDLE/RUN/DONE), default WIDTH/CHUNK constants, NCHUNK helper function.
- Sub-module chunk_adder: combinational CHUNK-bit adder with cin, sum, cout and carry-into-MSB outputs; one instance, shared across slices by index muxing.

## Test plan
- WIDTH=16, CHUNK=4: a=0x1234, b=0x0FFF, sub=0, cin=0 → result 0x2233, carry_out 0, overflow 0, out_valid exactly 4 cycles after acceptance.
- a=0x0005, b=0x0007, sub=1, cin=1 → result 0xFFFE, carry_out 0 (borrow), overflow 0.
- a=0x7FFF, b=0x0001, sub=0, cin=0 → result 0x8000, carry_out 0, overflow 1 with macro, 0 without; a=0x8000, b=0x0001, sub=1, cin=1 → 0x7FFF, carry_out 1, overflow 1 (macro on).
- Full carry ripple: a=0xFFFF, b=0x0000, sub=0, cin=1 → result 0x0000, carry_out 1, overflow 0.
- Backpressure: out_ready low 3 cycles in DONE → out_valid and result held, in_ready 0, concurrent in_valid with new operands ignored; after out_ready, next op accepted one cycle later and correct.
- Reset asserted 2 cycles into RUN → next cycle out_valid 0, in_ready 1, result 0; following op 0x1234+0x0FFF completes correctly.
